// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, ALU operation
// codes, opcode/funct values and exception causes.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_EXC    = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_BEQ  = 4'd9;
  localparam logic [3:0] ALU_BNE  = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd1;
  localparam logic [1:0] EXC_OVERFLOW = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

endpackage

// File: rtl/mips_alu_dec.sv
// Combinational instruction decoder: opcode/funct to ALU operation, operand
// select, destination select and a legality flag.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] fn_i,
  output logic [3:0] alu_ctrl_o,
  output logic       alu_src_o,
  output logic       reg_dst_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    alu_src_o  = 1'b0;
    reg_dst_o  = 1'b0;
    legal_o    = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        reg_dst_o = 1'b1;
        case (fn_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_ADDU: alu_ctrl_o = ALU_ADDU;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_SUBU: alu_ctrl_o = ALU_SUBU;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLL:  alu_ctrl_o = ALU_SLL;
          FN_SRL:  alu_ctrl_o = ALU_SRL;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: legal_o    = 1'b0;
        endcase
      end
      OP_ADDI: alu_src_o = 1'b1;
      OP_LW, OP_SW: begin
        alu_ctrl_o = ALU_ADDU;
        alu_src_o  = 1'b1;
      end
      OP_BEQ:  alu_ctrl_o = ALU_BEQ;
      OP_BNE:  alu_ctrl_o = ALU_BNE;
      default: legal_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/EXC) with memory wait timeout.
// Define MIPS_MC_CTRL_EXC_EN to trap illegal/overflow/timeout into a sticky EXC state.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       memReady,
  output logic [3:0] aluCtrl,
  output logic       aluSrc,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       memRead,
  output logic       memWrite,
  output logic       exception,
  output logic [1:0] excCause,
  output logic [2:0] state
);

  localparam int WW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_WAIT_MAX);

  state_t        state_q, state_d;
  logic [5:0]    op_q, fn_q;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    fault_code;
  logic [5:0]    dec_op, dec_fn;
  logic [3:0]    dec_ctrl;
  logic          dec_src, dec_regdst, dec_legal;
  logic          timeout, is_lw, is_sw, is_br;

  // The raw instruction is only consulted for the legality check in DECODE;
  // everything issued from EXEC onward comes from the latched copies.
  assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;
  assign dec_fn = (state_q == ST_DECODE) ? funct  : fn_q;

  mips_alu_dec u_dec (
    .op_i       (dec_op),
    .fn_i       (dec_fn),
    .alu_ctrl_o (dec_ctrl),
    .alu_src_o  (dec_src),
    .reg_dst_o  (dec_regdst),
    .legal_o    (dec_legal)
  );

  assign is_lw   = (op_q == OP_LW);
  assign is_sw   = (op_q == OP_SW);
  assign is_br   = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign timeout = (wait_q == WAIT_MAX) && !memReady;
  assign state   = rst ? ST_FETCH : state_q;

  always_comb begin
    state_d    = state_q;
    fault_code = EXC_NONE;
    aluCtrl    = ALU_ADD;
    aluSrc     = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    regWrite   = 1'b0;
    regDst     = 1'b0;
    memToReg   = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memRead = 1'b1;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          fault_code = EXC_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (dec_legal) state_d = ST_EXEC;
        else           fault_code = EXC_ILLEGAL;
      end
      ST_EXEC: begin
        aluCtrl = dec_ctrl;
        aluSrc  = dec_src;
        if (is_br) begin
          pcWrite = !zero;
          pcSrc   = !zero;
          state_d = ST_FETCH;
        end else if (overflow && (dec_ctrl == ALU_ADD || dec_ctrl == ALU_SUB)) begin
          fault_code = EXC_OVERFLOW;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        memRead  = is_lw;
        memWrite = is_sw;
        if (memReady)     state_d = is_lw ? ST_WB : ST_FETCH;
        else if (timeout) fault_code = EXC_TIMEOUT;
      end
      ST_WB: begin
        regWrite = 1'b1;
        regDst   = dec_regdst;
        memToReg = is_lw;
        state_d  = ST_FETCH;
      end
`ifdef MIPS_MC_CTRL_EXC_EN
      ST_EXC:  state_d = ST_EXC;
`endif
      default: state_d = ST_FETCH;
    endcase

`ifdef MIPS_MC_CTRL_EXC_EN
    if (fault_code != EXC_NONE) state_d = ST_EXC;
`else
    if (fault_code != EXC_NONE) state_d = ST_FETCH;
`endif

    // A fault restarting FETCH from FETCH is still a fresh access.
    if (state_d != state_q || fault_code != EXC_NONE)
      wait_d = '0;
    else if ((state_q == ST_FETCH || state_q == ST_MEM) && !memReady && wait_q != WAIT_MAX)
      wait_d = wait_q + 1'b1;
    else
      wait_d = wait_q;

    if (rst) begin
      aluCtrl  = ALU_ADD;
      aluSrc   = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      pcSrc    = 1'b0;
      regWrite = 1'b0;
      regDst   = 1'b0;
      memToReg = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == ST_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

`ifdef MIPS_MC_CTRL_EXC_EN
  logic       exc_q;
  logic [1:0] cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q   <= 1'b0;
      cause_q <= EXC_NONE;
    end else if (!exc_q && fault_code != EXC_NONE) begin
      exc_q   <= 1'b1;
      cause_q <= fault_code;
    end
  end

  assign exception = exc_q && !rst;
  assign excCause  = rst ? EXC_NONE : cause_q;
`else
  assign exception = 1'b0;
  assign excCause  = EXC_NONE;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks instruction classes, waits, traps and
// reset-abort; builds with or without MIPS_MC_CTRL_EXC_EN.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, overflow, memReady;
  logic [3:0] aluCtrl;
  logic       aluSrc, irWrite, pcWrite, pcSrc, regWrite, regDst, memToReg;
  logic       memRead, memWrite, exception;
  logic [1:0] excCause;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_WAIT_MAX(255)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .memReady(memReady), .aluCtrl(aluCtrl), .aluSrc(aluSrc),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
    .regDst(regDst), .memToReg(memToReg), .memRead(memRead), .memWrite(memWrite),
    .exception(exception), .excCause(excCause), .state(state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input string tag);
    memReady = 1'b1;
    #1;
    $display("txn %s: FETCH state=%0d memRead=%0b irWrite=%0b", tag, state, memRead, irWrite);
    chk({tag, "_fetch_state"}, 8'(state), 8'd0);
    chk({tag, "_fetch_strobes"}, {4'd0, memRead, irWrite, pcWrite, pcSrc}, 8'b1110);
    cyc();
  endtask

  task automatic decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    #1;
    chk({tag, "_decode_state"}, 8'(state), 8'd1);
    cyc();
    opcode = 6'h3F;  // scrambled: later stages must use the latched copy
    funct  = 6'h3F;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_rst_state"}, 8'(state), 8'd0);
    chk({tag, "_rst_outs"}, {memWrite, memRead, regWrite, pcWrite, exception, excCause, 1'b0}, 8'd0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0; memReady = 1'b0;
    repeat (3) @(posedge clk);
    #1 memReady = 1'b1;
    #1;
    // Reset: everything quiet while rst is high even with memReady asserted.
    chk("reset_state", 8'(state), 8'd0);
    chk("reset_strobes", {memRead, irWrite, pcWrite, regWrite, memWrite, aluSrc, 2'b00}, 8'd0);
    chk("reset_aluctrl", 8'(aluCtrl), 8'd0);
    chk("reset_exc", {5'd0, exception, excCause}, 8'd0);
    cyc();
    rst = 1'b0;

    // add: 4 cycles FETCH, DECODE, EXEC, WB.
    fetch_ok("add");
    decode("add", 6'h00, 6'h20);
    #1;
    chk("add_exec_state", 8'(state), 8'd2);
    chk("add_exec_alu", {aluCtrl, aluSrc, regWrite, 2'b00}, {4'd0, 1'b0, 1'b0, 2'b00});
    cyc();
    chk("add_wb", {state, 2'b00, regWrite, regDst, memToReg}, {3'd4, 2'b00, 3'b110});
    cyc();
    chk("add_back_fetch", 8'(state), 8'd0);
    $display("txn add: done, state=%0d", state);

    // lw with three memReady-low cycles in MEM: 8 cycles total.
    fetch_ok("lw");
    decode("lw", 6'h23, 6'h00);
    #1;
    chk("lw_exec_alu", {aluCtrl, aluSrc, 3'b000}, {4'd1, 1'b1, 3'b000});
    cyc();
    memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_mem_wait", {state, 3'b000, memRead, memWrite}, {3'd3, 3'b000, 2'b10});
      cyc();
    end
    memReady = 1'b1;
    #1;
    chk("lw_mem_ready", {state, 3'b000, memRead, memWrite}, {3'd3, 3'b000, 2'b10});
    cyc();
    chk("lw_wb", {state, 2'b00, regWrite, regDst, memToReg}, {3'd4, 2'b00, 3'b101});
    cyc();
    chk("lw_back_fetch", 8'(state), 8'd0);
    $display("txn lw: 3 waits, state=%0d", state);

    // beq taken (zero=0) and not taken (zero=1); bne code.
    fetch_ok("beq_t");
    decode("beq_t", 6'h04, 6'h00);
    zero = 1'b0;
    #1;
    chk("beq_taken", {aluCtrl, 2'b00, pcWrite, pcSrc}, {4'd9, 2'b00, 2'b11});
    cyc();
    chk("beq_taken_fetch", 8'(state), 8'd0);
    fetch_ok("beq_n");
    decode("beq_n", 6'h04, 6'h00);
    zero = 1'b1;
    #1;
    chk("beq_not_taken", {aluCtrl, 2'b00, pcWrite, pcSrc}, {4'd9, 2'b00, 2'b00});
    cyc();
    chk("beq_nt_fetch", 8'(state), 8'd0);
    fetch_ok("bne");
    decode("bne", 6'h05, 6'h00);
    zero = 1'b0;
    #1;
    chk("bne_exec", {aluCtrl, aluSrc, pcWrite, pcSrc, 1'b0}, {4'd10, 1'b0, 2'b11, 1'b0});
    cyc();
    zero = 1'b0;
    $display("txn branches: state=%0d", state);

    // addi: immediate operand, regDst=0.
    fetch_ok("addi");
    decode("addi", 6'h08, 6'h15);
    #1;
    chk("addi_exec", {aluCtrl, aluSrc, 3'b000}, {4'd0, 1'b1, 3'b000});
    cyc();
    chk("addi_wb", {state, 2'b00, regWrite, regDst, memToReg}, {3'd4, 2'b00, 3'b100});
    cyc();

    // slt and sll R-type codes.
    fetch_ok("slt");
    decode("slt", 6'h00, 6'h2A);
    #1;
    chk("slt_exec", 8'(aluCtrl), 8'd8);
    cyc(); cyc();
    fetch_ok("sll");
    decode("sll", 6'h00, 6'h00);
    #1;
    chk("sll_exec", 8'(aluCtrl), 8'd6);
    cyc(); cyc();

    // sw with memReady=1: 4 cycles, memWrite one pulse.
    fetch_ok("sw");
    decode("sw", 6'h2B, 6'h00);
    #1;
    chk("sw_exec", {aluCtrl, aluSrc, 3'b000}, {4'd1, 1'b1, 3'b000});
    cyc();
    chk("sw_mem", {state, 3'b000, memRead, memWrite}, {3'd3, 3'b000, 2'b01});
    cyc();
    chk("sw_back_fetch", {state, 4'd0, memWrite}, 8'd0);
    $display("txn sw: state=%0d", state);

    // Illegal opcode 0x3F.
    fetch_ok("ill");
    decode("ill", 6'h3F, 6'h00);
    #1;
`ifdef MIPS_MC_CTRL_EXC_EN
    chk("ill_exc", {state, 2'b00, exception, excCause}, {3'd5, 2'b00, 1'b1, 2'd1});
    cyc(); cyc();
    chk("ill_exc_hold", {state, memRead, irWrite, exception, excCause}, {3'd5, 2'b00, 1'b1, 2'd1});
`else
    chk("ill_fetch", {state, 2'b00, exception, excCause}, 8'd0);
`endif
    do_reset("ill");

    // sub with overflow: no regWrite.
    fetch_ok("sub");
    decode("sub", 6'h00, 6'h22);
    overflow = 1'b1;
    #1;
    chk("sub_exec", {aluCtrl, 3'b000, regWrite}, {4'd2, 4'b0000});
    cyc();
    overflow = 1'b0;
    #1;
`ifdef MIPS_MC_CTRL_EXC_EN
    chk("sub_ovf_exc", {state, 1'b0, regWrite, exception, excCause}, {3'd5, 2'b00, 1'b1, 2'd2});
`else
    chk("sub_ovf_skip", {state, 1'b0, regWrite, exception, excCause}, 8'd0);
`endif
    do_reset("sub");

    // Reset pulsed while sw waits in MEM: no write after that edge.
    fetch_ok("swr");
    decode("swr", 6'h2B, 6'h00);
    cyc();
    memReady = 1'b0;
    #1;
    chk("swr_mem_wait", {state, 4'd0, memWrite}, {3'd3, 4'd0, 1'b1});
    cyc();
    rst = 1'b1;
    memReady = 1'b1;
    #1;
    chk("swr_rst_nowrite", 8'(memWrite), 8'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("swr_after", {state, 3'b000, memWrite, memRead}, {3'd0, 3'b000, 2'b01});
    $display("txn sw_rst: state=%0d memWrite=%0b", state, memWrite);

    // Memory timeout in MEM: 255 low cycles tolerated, the 256th traps.
    fetch_ok("tmo");
    decode("tmo", 6'h2B, 6'h00);
    cyc();
    memReady = 1'b0;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (i == 0 || i == 255) chk("tmo_in_mem", {state, 4'd0, memWrite}, {3'd3, 4'd0, 1'b1});
      cyc();
    end
    #1;
`ifdef MIPS_MC_CTRL_EXC_EN
    chk("tmo_exc", {state, 2'b00, exception, excCause}, {3'd5, 2'b00, 1'b1, 2'd3});
`else
    chk("tmo_fetch", {state, 2'b00, exception, excCause}, 8'd0);
`endif
    $display("txn timeout: state=%0d cause=%0d", state, excCause);
    do_reset("tmo");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 255: maximum consecutive memReady-low cycles tolerated in one memory state.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  6  instruction bits [31:26], valid while state is DECODE.
REQ-005 funct  input  6  instruction bits [5:0], valid while state is DECODE.
REQ-006 zero, overflow  input  1 each  ALU flags, sampled in EXEC.
REQ-007 memReady  input  1  memory completes the current access this cycle.
REQ-008 aluCtrl  output  4  ALU operation: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 sll, 7 srl, 8 slt, 9 beq, 10 bne.
REQ-009 aluSrc  output  1  0 selects register data2, 1 selects immediate.
REQ-010 irWrite, pcWrite, pcSrc  output  1 each  IR load, PC load, PC source (0 = PC+4, 1 = branch target).
REQ-011 regWrite, regDst, memToReg, memRead, memWrite  output  1 each  datapath strobes/selects.
REQ-012 exception  output  1  sticky trap flag; excCause  output  2  (0 none, 1 illegal, 2 overflow, 3 memory timeout).
REQ-013 state  output  3  current state encoding for debug.

Function
REQ-014 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, EXC=5; codes 6-7 SHALL go to FETCH.
REQ-015 FETCH: memRead=1; when memReady=1, irWrite=1, pcWrite=1, pcSrc=0 for that cycle and next state DECODE; otherwise stay.
REQ-016 DECODE: latch opcode/funct into internal registers; decoded aluCtrl/aluSrc SHALL come only from latched copies from EXEC onward.
REQ-017 Legal set: R-type (opcode 0) funct 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x00 sll, 0x02 srl, 0x2A slt; opcodes 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne.
REQ-018 EXEC: R-type aluSrc=0; addi aluCtrl=0 aluSrc=1; lw/sw aluCtrl=1 aluSrc=1; beq aluCtrl=9, bne aluCtrl=10, aluSrc=0.
REQ-019 Branch in EXEC: taken when zero=0 (ALU result 1); taken -> pcWrite=1, pcSrc=1; next FETCH in both cases.
REQ-020 Overflow=1 in EXEC with aluCtrl 0 or 2: regWrite SHALL never assert for that instruction.
REQ-021 EXEC next: lw/sw -> MEM; R-type/addi -> WB.
REQ-022 MEM: lw memRead=1, sw memWrite=1, held until memReady=1; sw -> FETCH, lw -> WB.
REQ-023 WB: regWrite=1 one cycle; regDst=1 for R-type, 0 for addi/lw; memToReg=1 only for lw; next FETCH.
REQ-024 Wait counter SHALL clear on entry to FETCH/MEM, increment per memReady-low cycle, saturate; reaching MEM_WAIT_MAX is a timeout.
REQ-025 Latency with memReady=1: beq/bne 3 cycles, R-type/addi/sw 4, lw 5; each wait cycle adds one.
REQ-026 All strobes SHALL be single-cycle pulses decoded from registered state; no output asserts in two states at once.

Reset
REQ-027 While rst=1: state=FETCH, all strobes 0, aluCtrl=0, aluSrc=0, exception=0, excCause=0, wait counter 0; first fetch strobe the cycle after rst falls.
REQ-028 rst mid-access (MEM/FETCH) SHALL abort the access with no write completing after that edge.

Configuration
REQ-029 Macro MIPS_MC_CTRL_EXC_EN: defined -> illegal decode, overflow (REQ-020) and timeout enter EXC, set exception=1 with cause, hold until rst, all strobes 0.
REQ-030 Undefined -> EXC unreachable, exception/excCause tied 0; illegal decode and timeout go to FETCH, overflow skips WB and goes to FETCH.

Structure
REQ-031 Shared package mips_pkg SHALL hold state encoding, aluCtrl codes, opcode/funct constants, excCause codes.
REQ-032 One sub-module mips_alu_dec: combinational latched opcode/funct -> aluCtrl, aluSrc, regDst, legal flag.

Verification
REQ-033 add ($funct 0x20), memReady=1 -> FETCH,DECODE,EXEC(aluCtrl=0),WB(regWrite=1,regDst=1), 4 cycles.
REQ-034 lw with memReady low 3 cycles in MEM -> memRead held 4 cycles, WB memToReg=1, total 8 cycles.
REQ-035 beq with zero=0 -> pcWrite=1, pcSrc=1 in EXEC; zero=1 -> pcWrite=0; both return to FETCH.
REQ-036 opcode 0x3F with EXC_EN -> EXC, exception=1, excCause=1 until rst; without -> FETCH next.
REQ-037 sub with overflow=1 -> no regWrite; EXC_EN gives excCause=2.
REQ-038 rst pulsed during sw MEM wait -> memWrite 0 next cycle, state FETCH.
